// File: rtl/md_unit.sv
// rtl/md_unit.sv - iterative RV32M multiply/divide unit for the EX stage
// FAST_MUL_EN: when defined, MUL* ops use a single-cycle product (latency 2)
module md_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            start,
  input  logic [2:0]      MD_func,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  output logic            busy,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] MD_out
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIN
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0]   count;
  logic [2:0]      func;
  logic [XLEN-1:0] opnd;
  logic [XLEN-1:0] acc_hi;
  logic [XLEN-1:0] acc_lo;
  logic            sgn_q;
  logic            sgn_r;
  logic            div0;
  logic            ovf;

  // operand decode at launch
  logic            op1_signed;
  logic            op2_signed;
  logic            neg1;
  logic            neg2;
  logic [XLEN-1:0] mag1;
  logic [XLEN-1:0] mag2;
  logic            fast_mul;

  assign op1_signed = !((MD_func == 3'b011) || (MD_func[2] && MD_func[0]));
  assign op2_signed = op1_signed && (MD_func != 3'b010);
  assign neg1       = op1_signed && op1[XLEN-1];
  assign neg2       = op2_signed && op2[XLEN-1];
  assign mag1       = neg1 ? -op1 : op1;
  assign mag2       = neg2 ? -op2 : op2;

`ifdef FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod;
  assign fast_prod = {{XLEN{1'b0}}, mag1} * {{XLEN{1'b0}}, mag2};
  assign fast_mul  = !MD_func[2];
`else
  assign fast_mul  = 1'b0;
`endif

  // one shift-add (multiply) or restoring shift-subtract (divide) step
  logic [XLEN:0] mul_sum;
  logic [XLEN:0] div_shift;
  logic [XLEN:0] div_diff;

  assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
  assign div_shift = {acc_hi, acc_lo[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, opnd};

  // sign correction and special-case forcing applied in FIN
  logic [2*XLEN-1:0] prod;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo_s;
  logic [XLEN-1:0]   rem_s;
  logic [XLEN-1:0]   fin_result;

  assign prod   = {acc_hi, acc_lo};
  assign prod_s = sgn_q ? -prod : prod;
  assign quo_s  = sgn_q ? -acc_lo : acc_lo;
  assign rem_s  = sgn_r ? -acc_hi : acc_hi;

  always_comb begin
    fin_result = '0;
    case (func)
      3'b000:                 fin_result = prod_s[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fin_result = prod_s[2*XLEN-1:XLEN];
      3'b100, 3'b101: begin
        if (div0)     fin_result = '1;
        else if (ovf) fin_result = MIN_NEG;
        else          fin_result = quo_s;
      end
      default: begin
        if (ovf) fin_result = '0;
        else     fin_result = rem_s;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = fast_mul ? FIN : CALC;
      CALC:    if (count == '0) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= '0;
      func   <= '0;
      opnd   <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      sgn_q  <= 1'b0;
      sgn_r  <= 1'b0;
      div0   <= 1'b0;
      ovf    <= 1'b0;
      done   <= 1'b0;
      MD_out <= '0;
    end else begin
      done <= 1'b0;
      if (!flush) begin
        case (state)
          IDLE: begin
            if (start) begin
              func   <= MD_func;
              sgn_q  <= neg1 ^ neg2;
              sgn_r  <= neg1;
              div0   <= MD_func[2] && (op2 == '0);
              ovf    <= MD_func[2] && !MD_func[0] && (op1 == MIN_NEG) && (op2 == '1);
              count  <= CW'(XLEN - 1);
              // multiply: opnd = multiplicand, acc_lo = multiplier
              // divide:   opnd = divisor,      acc_lo = dividend -> quotient
              opnd   <= MD_func[2] ? mag2 : mag1;
              acc_hi <= '0;
              acc_lo <= MD_func[2] ? mag1 : mag2;
`ifdef FAST_MUL_EN
              if (!MD_func[2]) {acc_hi, acc_lo} <= fast_prod;
`endif
            end
          end
          CALC: begin
            if (func[2]) begin
              if (!div_diff[XLEN]) begin
                acc_hi <= div_diff[XLEN-1:0];
                acc_lo <= {acc_lo[XLEN-2:0], 1'b1};
              end else begin
                acc_hi <= div_shift[XLEN-1:0];
                acc_lo <= {acc_lo[XLEN-2:0], 1'b0};
              end
            end else begin
              acc_hi <= mul_sum[XLEN:1];
              acc_lo <= {mul_sum[0], acc_lo[XLEN-1:1]};
            end
            if (count != '0) count <= count - 1'b1;
          end
          FIN: begin
            MD_out <= fin_result;
            done   <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign busy  = (state != IDLE);
  assign stall = start | busy;

endmodule

// File: tb/tb_md_unit.sv
// tb/tb_md_unit.sv - scoreboard bench for md_unit (honours FAST_MUL_EN)
module tb_md_unit;

`ifdef FAST_MUL_EN
  localparam int LAT_MUL = 1;
`else
  localparam int LAT_MUL = 33;
`endif
  localparam int LAT_DIV = 33;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  MD_func = 3'b000;
  logic [31:0] op1 = '0;
  logic [31:0] op2 = '0;
  logic        busy;
  logic        stall;
  logic        done;
  logic [31:0] MD_out;

  md_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .start(start), .MD_func(MD_func),
    .op1(op1), .op2(op2), .busy(busy), .stall(stall), .done(done), .MD_out(MD_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] val;
    int          edge_e0;
    int          lat;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // monitor: every done must match the oldest expected result and latency
  always @(negedge clk) begin
    if (!rst && done) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done actual=%h required=no_done", MD_out);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("result", MD_out, e.val);
        chk("latency", 32'(cyc - e.edge_e0), 32'(e.lat));
      end
    end
  end

  // call just after a negedge; returns one negedge later with start low
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] expv, input bit push);
    exp_t e;
    start = 1'b1; MD_func = f; op1 = a; op2 = b;
    if (push) begin
      e.val = expv;
      e.edge_e0 = cyc + 1;
      e.lat = f[2] ? LAT_DIV : LAT_MUL;
      q.push_back(e);
    end
    #1 chk("stall_on_start", {31'b0, stall}, 32'd1);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      chk("done_timeout", 32'(q.size()), 32'd0);
      q.delete();
    end
    @(negedge clk);
  endtask

  task automatic run(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] expv);
    issue(f, a, b, expv, 1'b1);
    chk("busy_after_start", {31'b0, busy}, 32'd1);
    wait_idle();
  endtask

  logic [31:0] prev;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_md_out", MD_out, 32'd0);
    chk("rst_stall", {31'b0, stall}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run(3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB);
    run(3'b000, 32'h12345678, 32'h10,       32'h23456780);
    run(3'b001, 32'h80000000, 32'h80000000, 32'h40000000);
    run(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000);
    run(3'b011, 32'h80000000, 32'h80000000, 32'h40000000);
    run(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
    run(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
    run(3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD);
    run(3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF);
    run(3'b101, 32'hFFFFFFFF, 32'd16,       32'h0FFFFFFF);
    run(3'b111, 32'hFFFFFFFF, 32'd16,       32'h0000000F);
    run(3'b101, 32'h1234,     32'd0,        32'hFFFFFFFF);
    run(3'b110, 32'h1234,     32'd0,        32'h00001234);
    run(3'b100, 32'hFFFFEDCC, 32'd0,        32'hFFFFFFFF);
    run(3'b110, 32'hFFFFEDCC, 32'd0,        32'hFFFFEDCC);
    run(3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
    run(3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000);

    // start in the done cycle launches the next op; old result held meanwhile
    issue(3'b000, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 1'b1);
    begin
      int n = 0;
      while (!done && n < 100) begin
        @(negedge clk);
        n++;
      end
      chk("b2b_done_seen", {31'b0, done}, 32'd1);
    end
    issue(3'b101, 32'd100, 32'd7, 32'd14, 1'b1);
    chk("b2b_md_out_held", MD_out, 32'hFFFFFFEB);
    chk("b2b_busy", {31'b0, busy}, 32'd1);
    wait_idle();

    // flush mid-divide: no done, result kept
    prev = MD_out;
    issue(3'b100, 32'd1000, 32'd3, 32'd0, 1'b0);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", {31'b0, busy}, 32'd0);
    chk("flush_done", {31'b0, done}, 32'd0);
    chk("flush_md_out", MD_out, prev);

    // flush beats a simultaneous start
    flush = 1'b1;
    issue(3'b100, 32'd1000, 32'd3, 32'd0, 1'b0);
    flush = 1'b0;
    chk("flush_start_busy", {31'b0, busy}, 32'd0);
    run(3'b111, 32'd1000, 32'd3, 32'd1);
    repeat (40) @(negedge clk);

    // start while busy is ignored
    issue(3'b100, 32'd1000, 32'hFFFFFFFD, 32'hFFFFFEB3, 1'b1);
    repeat (4) @(negedge clk);
    issue(3'b000, 32'd5, 32'd5, 32'd0, 1'b0);
    wait_idle();
    repeat (40) @(negedge clk);

    // reset mid-operation
    issue(3'b101, 32'd50000, 32'd7, 32'd0, 1'b0);
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    chk("midrst_done", {31'b0, done}, 32'd0);
    chk("midrst_md_out", MD_out, 32'd0);
    chk("midrst_stall", {31'b0, stall}, 32'd0);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
